// File: rtl/led_pkg.sv
// Shared defaults and helper functions for the LED PWM driver and its tick generator.
package led_pkg;

   localparam int unsigned LED_WIDTH         = 8;
   localparam int unsigned LED_PWM_BITS      = 8;
   localparam int unsigned LED_PRESCALE      = 50;
   localparam int unsigned LED_BLINK_PERIODS = 64;

   // Perceptual curve: square law, keeping the full-on code and never rounding a nonzero level to off.
   function automatic int unsigned led_gamma(input int unsigned b, input int unsigned bits);
      int unsigned max_v;
      int unsigned g;
      max_v = (32'd1 << bits) - 32'd1;
      g     = (b * b) >> bits;
      if (b == max_v) begin
         g = max_v;
      end else if ((b != 32'd0) && (g == 32'd0)) begin
         g = 32'd1;
      end
      return g;
   endfunction

   function automatic logic led_duty_on(input int unsigned cnt, input int unsigned bright,
                                        input int unsigned bits);
      int unsigned max_v;
      max_v = (32'd1 << bits) - 32'd1;
      return (bright == max_v) || (cnt < bright);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler plus free-running PWM counter; flags the last tick of each PWM period as the boundary.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS = LED_PWM_BITS,
   parameter int unsigned PRESCALE = LED_PRESCALE
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic                tick,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                boundary
);

   localparam int unsigned     PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]       presc_q, presc_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

   assign tick     = (presc_q == PRESC_LAST);
   assign boundary = tick && (pwm_cnt_q == '1);
   assign pwm_cnt  = pwm_cnt_q;

   always_comb begin
      presc_d   = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

endmodule

// File: rtl/led_pwm_driver.sv
// LED pin driver: glitch-free pattern/brightness shadows, global PWM and per-LED blink.
// Define LED_GAMMA_EN to pass brightness through a square-law curve before it is latched.
module led_pwm_driver
   import led_pkg::*;
#(
   parameter int unsigned WIDTH         = LED_WIDTH,
   parameter int unsigned PWM_BITS      = LED_PWM_BITS,
   parameter int unsigned PRESCALE      = LED_PRESCALE,
   parameter int unsigned BLINK_PERIODS = LED_BLINK_PERIODS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [WIDTH-1:0]    pattern_in,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic [WIDTH-1:0]    blink_mask,
   output logic [WIDTH-1:0]    led_out,
   output logic                period_strobe
);

   localparam int unsigned   BW         = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

   logic                pwm_tick_unused;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                boundary;
   logic [PWM_BITS-1:0] bright_in;
   logic                duty;

   logic [WIDTH-1:0]    pattern_sh_q, pattern_sh_d;
   logic [PWM_BITS-1:0] bright_sh_q, bright_sh_d;
   logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                blink_phase_q, blink_phase_d;
   logic [WIDTH-1:0]    led_out_q, led_out_d;
   logic                period_strobe_q, period_strobe_d;

   led_tick_gen #(
      .PWM_BITS (PWM_BITS),
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (pwm_tick_unused),
      .pwm_cnt  (pwm_cnt),
      .boundary (boundary)
   );

`ifdef LED_GAMMA_EN
   assign bright_in = PWM_BITS'(led_gamma(32'(brightness), PWM_BITS));
`else
   assign bright_in = brightness;
`endif

   // Shadows and blink phase move only on the boundary so the pin drive never changes mid-period.
   always_comb begin
      pattern_sh_d    = pattern_sh_q;
      bright_sh_d     = bright_sh_q;
      blink_cnt_d     = blink_cnt_q;
      blink_phase_d   = blink_phase_q;
      period_strobe_d = boundary;
      if (boundary) begin
         pattern_sh_d = pattern_in;
         bright_sh_d  = bright_in;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
      duty      = led_duty_on(32'(pwm_cnt), 32'(bright_sh_q), PWM_BITS);
      led_out_d = pattern_sh_q & {WIDTH{duty}} & ~(blink_mask & {WIDTH{blink_phase_q}});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern_sh_q    <= '0;
         bright_sh_q     <= '0;
         blink_cnt_q     <= '0;
         blink_phase_q   <= 1'b0;
         led_out_q       <= '0;
         period_strobe_q <= 1'b0;
      end else begin
         pattern_sh_q    <= pattern_sh_d;
         bright_sh_q     <= bright_sh_d;
         blink_cnt_q     <= blink_cnt_d;
         blink_phase_q   <= blink_phase_d;
         led_out_q       <= led_out_d;
         period_strobe_q <= period_strobe_d;
      end
   end

   assign led_out       = led_out_q;
   assign period_strobe = period_strobe_q;

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
Consumes the 8-bit LED pattern register output of the Avalon-MM LED PIO and drives the physical LED pins. Adds global PWM brightness and per-LED blink. Pattern and brightness updates take effect only at PWM period boundaries, so the pins never glitch. Sits between the LED PIO output port and the top-level LED pins.

Parameters:
WIDTH, 8, number of LEDs / pattern bits
PWM_BITS, 8, PWM counter and brightness width
PRESCALE, 50, clk cycles per PWM tick (>=1)
BLINK_PERIODS, 64, PWM periods per blink half-phase (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pattern_in  in  WIDTH  LED on/off pattern from PIO out_port
brightness  in  PWM_BITS  global duty level; quasi-static
blink_mask  in  WIDTH  1 = LED blinks
led_out  out  WIDTH  registered LED pin drive, 1 = lit
period_strobe  out  1  one-cycle pulse at each PWM period start

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: led_out=0, period_strobe=0. Prescaler, pwm_cnt, blink counter, blink_phase, pattern_sh and bright_sh all 0.
- Prescaler counts 0..PRESCALE-1, then wraps. tick=1 on the cycle prescaler==PRESCALE-1. PRESCALE=1 gives tick every cycle.
- pwm_cnt increments on tick, PWM_BITS wide, wraps max->0 naturally.
- Boundary cycle = tick && pwm_cnt==all-ones. On that cycle, register:
  - pattern_sh<=pattern_in
  - bright_sh<=brightness (after gamma if enabled)
  - period_strobe<=1 for exactly one cycle
- Blink counter counts boundaries 0..BLINK_PERIODS-1. On wrap, blink_phase toggles, taking effect the same cycle as the new shadows.
- led_out[i] registered each cycle = pattern_sh[i] & duty & ~(blink_mask[i] & blink_phase).
  - duty = (pwm_cnt < bright_sh), except bright_sh all-ones forces duty=1 (true full-on, no gap).
  - bright_sh=0 gives LED constantly off.
- blink_mask is sampled live (not shadowed).
- Latency: new pattern/brightness appear on led_out 1 clk after period_strobe rises. Worst case from input change: one PWM period + 2 clk.
- Input changing on the boundary cycle itself is captured in that boundary.
- Reset mid-operation clears all state immediately. The first boundary after release occurs PRESCALE*2^PWM_BITS clk later. Until then the shadows are 0, so LEDs stay dark.
- Arithmetic: all counters unsigned; no saturation needed.

Optional Feature:
LED_GAMMA_EN
- Defined: brightness passes through a perceptual curve before latching: g=(b*b)>>PWM_BITS, with b=all-ones mapped to all-ones and b!=0 giving g>=1. The curve is combinational, computed before the shadow register.
- Not defined: bright_sh latches brightness unchanged (linear).

Decomposition:
- Package led_pkg:
  - default parameter constants
  - function for gamma mapping
  - function for full-on comparison
- Sub-module led_tick_gen: prescaler plus pwm_cnt, outputs tick, pwm_cnt, boundary. Reusable for other PWM'd indicators.
- Top: shadows, blink logic, output register.

Test Plan:
Bench overrides: PRESCALE=4, PWM_BITS=4, BLINK_PERIODS=2; period = 64 clk.
1. Reset check: hold reset_n=0 with pattern_in=0xFF, brightness=15 -> led_out=0x00 and period_strobe=0. After release, led_out stays 0 until 1 clk after the first strobe (clk 64).
2. Duty: pattern_in=0xFF, brightness=8, mask=0 -> led_out=0xFF for 32 clk, then 0x00 for 32 clk, each period. Strobe spacing exactly 64 clk.
3. Extremes: brightness=0 -> led_out 0x00 for a full period. brightness=15 -> led_out constant 0xFF with no low cycle across 3 periods.
4. Mid-period update: pattern 0xAA to 0x55 at clk 20 of a period -> led_out keeps 0xAA-gated until the boundary, then shows 0x55 1 clk after period_strobe.
5. Blink: pattern_in=0xFF, brightness=15, mask=0x0F -> upper nibble lit continuously. Lower nibble lit 2 periods, dark 2 periods, repeating.
6. Reset mid-period: assert reset_n=0 at clk 30 of a lit period -> led_out=0 asynchronously, before the next clk edge. After release, counters restart (next strobe 64 clk later). With LED_GAMMA_EN, brightness=8 gives 4 high clk-ticks per period (16 clk).
